// File: rtl/ws2812_frame_scheduler.sv
// Frame-rate driven readout of the WS2812 pixel RAM into the bit serializer.
// Each frame streams pixels 0..depth-1, then holds the line idle for the latch gap.
module ws2812_frame_scheduler #(
  parameter int ADDR_WIDTH   = 10,
  parameter int LATCH_CYCLES = 5000,
  parameter int FRAME_PERIOD = 1666667,
  parameter int CNT_WIDTH    = 24
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [15:0]           data_depth,
  input  logic                  write_config,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  input  logic [23:0]           mem_rd_data,
  output logic                  tx_valid,
  output logic [23:0]           tx_data,
  input  logic                  tx_ready,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  frame_overrun
);

  // One extra bit so a full 2^ADDR_WIDTH frame never wraps the index.
  localparam int IW = ADDR_WIDTH + 1;
  localparam int CW = (IW > 16) ? IW : 16;
  localparam logic [IW-1:0]        MAX_DEPTH  = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [CNT_WIDTH-1:0] FRAME_LAST = CNT_WIDTH'(FRAME_PERIOD - 1);
  localparam logic [CNT_WIDTH-1:0] LATCH_LAST = CNT_WIDTH'(LATCH_CYCLES - 1);

  typedef enum logic [2:0] {
    WAIT_TICK,
    RD_ISSUE,
    RD_WAIT,
    SEND,
    LATCH
  } state_t;

  state_t                  state_reg;
  logic [15:0]             depth_reg;
  logic [IW-1:0]           shadow_reg;
  logic [IW-1:0]           index_reg;
  logic [CNT_WIDTH-1:0]    frame_cnt_reg;
  logic [CNT_WIDTH-1:0]    latch_cnt_reg;
  logic                    pending_reg;
  logic                    mem_rd_en_reg;
  logic [ADDR_WIDTH-1:0]   mem_rd_addr_reg;
  logic                    tx_valid_reg;
  logic [23:0]             tx_data_reg;
  logic                    busy_reg;
  logic                    frame_done_reg;

  logic                    tick;
  logic                    frame_start;
  logic [IW-1:0]           depth_clamped;
  logic [IW-1:0]           index_inc;
  logic                    last_pixel;

  assign tick          = (frame_cnt_reg == FRAME_LAST);
  assign frame_start   = (state_reg == WAIT_TICK) && pending_reg && enable;
  assign depth_clamped = (CW'(depth_reg) > CW'(MAX_DEPTH)) ? MAX_DEPTH : IW'(depth_reg);
  assign index_inc     = index_reg + IW'(1);
  assign last_pixel    = (index_inc == shadow_reg);

  // A tick that finds a frame already pending is dropped; a tick coinciding
  // with a frame start simply re-arms pending.
  assign frame_overrun = tick && pending_reg && !frame_start;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt_reg <= '0;
      pending_reg   <= 1'b0;
    end else begin
      frame_cnt_reg <= tick ? '0 : frame_cnt_reg + CNT_WIDTH'(1);
      pending_reg   <= tick || (pending_reg && !frame_start);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= WAIT_TICK;
      depth_reg       <= 16'd1000;
      shadow_reg      <= '0;
      index_reg       <= '0;
      latch_cnt_reg   <= '0;
      mem_rd_en_reg   <= 1'b0;
      mem_rd_addr_reg <= '0;
      tx_valid_reg    <= 1'b0;
      tx_data_reg     <= '0;
      busy_reg        <= 1'b0;
      frame_done_reg  <= 1'b0;
    end else begin
      if (write_config) begin
        depth_reg <= data_depth;
      end
      case (state_reg)
        WAIT_TICK: begin
          if (frame_start) begin
            shadow_reg <= depth_clamped;
            index_reg  <= '0;
            busy_reg   <= 1'b1;
            if (depth_clamped == '0) begin
              state_reg      <= LATCH;
              latch_cnt_reg  <= '0;
              frame_done_reg <= (LATCH_CYCLES == 1);
            end else begin
              state_reg       <= RD_ISSUE;
              mem_rd_en_reg   <= 1'b1;
              mem_rd_addr_reg <= '0;
            end
          end
        end
        RD_ISSUE: begin
          mem_rd_en_reg <= 1'b0;
          state_reg     <= RD_WAIT;
        end
        RD_WAIT: begin
          tx_data_reg  <= mem_rd_data;
          tx_valid_reg <= 1'b1;
          state_reg    <= SEND;
        end
        SEND: begin
          if (tx_ready) begin
            tx_valid_reg <= 1'b0;
            if (last_pixel) begin
              state_reg      <= LATCH;
              latch_cnt_reg  <= '0;
              frame_done_reg <= (LATCH_CYCLES == 1);
            end else begin
              index_reg       <= index_inc;
              mem_rd_en_reg   <= 1'b1;
              mem_rd_addr_reg <= index_inc[ADDR_WIDTH-1:0];
              state_reg       <= RD_ISSUE;
            end
          end
        end
        LATCH: begin
          // frame_done is raised one edge early so it marks the final latch cycle.
          if (latch_cnt_reg == LATCH_LAST) begin
            state_reg      <= WAIT_TICK;
            busy_reg       <= 1'b0;
            frame_done_reg <= 1'b0;
          end else begin
            latch_cnt_reg  <= latch_cnt_reg + CNT_WIDTH'(1);
            frame_done_reg <= (latch_cnt_reg + CNT_WIDTH'(1) == LATCH_LAST);
          end
        end
        default: begin
          state_reg <= WAIT_TICK;
        end
      endcase
    end
  end

  assign mem_rd_en   = mem_rd_en_reg;
  assign mem_rd_addr = mem_rd_addr_reg;
  assign tx_valid    = tx_valid_reg;
  assign tx_data     = tx_data_reg;
  assign busy        = busy_reg;
  assign frame_done  = frame_done_reg;

endmodule

// File: tb/tb_ws2812_frame_scheduler.sv
// Bench for ws2812_frame_scheduler: stimulus and expected events are built up front
// from a timing-level model; a negedge monitor compares DUT activity against them.
module tb_ws2812_frame_scheduler;

  localparam int P         = 100;
  localparam int L         = 10;
  localparam int AW        = 10;
  localparam int DEPTH_MAX = 1 << AW;
  localparam int MAXC      = 20000;

  logic            clk = 1'b0;
  logic            rst;
  logic            enable;
  logic [15:0]     data_depth;
  logic            write_config;
  logic            mem_rd_en;
  logic [AW-1:0]   mem_rd_addr;
  logic [23:0]     mem_rd_data;
  logic            tx_valid;
  logic [23:0]     tx_data;
  logic            tx_ready;
  logic            busy;
  logic            frame_done;
  logic            frame_overrun;

  ws2812_frame_scheduler #(
    .ADDR_WIDTH  (AW),
    .LATCH_CYCLES(L),
    .FRAME_PERIOD(P),
    .CNT_WIDTH   (24)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .data_depth   (data_depth),
    .write_config (write_config),
    .mem_rd_en    (mem_rd_en),
    .mem_rd_addr  (mem_rd_addr),
    .mem_rd_data  (mem_rd_data),
    .tx_valid     (tx_valid),
    .tx_data      (tx_data),
    .tx_ready     (tx_ready),
    .busy         (busy),
    .frame_done   (frame_done),
    .frame_overrun(frame_overrun)
  );

  always #5 clk = ~clk;

  // Pixel RAM with one-cycle registered read.
  logic [23:0] ram [DEPTH_MAX];
  logic [23:0] ram_q;
  always @(posedge clk) if (mem_rd_en) ram_q <= ram[mem_rd_addr];
  assign mem_rd_data = ram_q;

  typedef struct {
    int cyc;
    int val;
  } ev_t;

  ev_t q_rd[$];
  ev_t q_acc[$];
  ev_t q_done[$];
  ev_t q_ovr[$];

  bit          s_rst [MAXC];
  bit          s_en  [MAXC];
  bit          s_wc  [MAXC];
  bit          s_rdy [MAXC];
  logic [15:0] s_dd  [MAXC];
  bit          exp_busy  [MAXC];
  bit          exp_valid [MAXC];
  logic [23:0] exp_data  [MAXC];

  int nc = 0;
  int mcyc = 0;
  int compared = 0;
  int mismatched = 0;

  task automatic check(input string name, input longint act, input longint req);
    compared++;
    if (act != req) begin
      mismatched++;
      $display("FAIL %s at cycle %0d: got %0h, required %0h", name, mcyc, act, req);
    end
  endtask

  // Builds per-cycle stimulus and, from the timing rules, the expected events:
  // read 1 cycle after a frame start / accept, offer 3 cycles after, frame_done
  // LATCH cycles after the last accept (or after the start of an empty frame).
  task automatic build();
    int  t0 = 0;
    bit  pend = 0;
    int  dcfg = 1000;
    bit  act = 0;
    int  fdepth = 0, pix = 0, next_read = -1, offer_from = -1, done_at = -1;
    int  ph = 0, frames_done = 0, last_done_depth = -1, stall_left = 0;
    int  e_state = 0, e_wait = 0, e_done_mark = 0, d_start = 0, end_at = -1;
    bit  c_written = 0, zero_written = 0, big_written = 0;
    bit  tick, start, mvalid;
    int  d, n;

    for (int i = 0; i < DEPTH_MAX; i++) ram[i] = 24'($urandom);
    ram[0] = 24'h112233;
    ram[1] = 24'h445566;
    ram[2] = 24'h778899;

    n = 0;
    while (n < MAXC && !(end_at >= 0 && n >= end_at)) begin
      if (ph == 0 && frames_done >= 4) ph = 1;
      if (ph == 1 && frames_done >= 6) ph = 2;
      if (ph == 2 && frames_done >= 8) begin ph = 3; d_start = n; end
      if (ph == 3 && n - d_start >= 1500) ph = 4;
      if (ph == 4 && e_state == 2 && frames_done > e_done_mark) ph = 5;

      s_rst[n] = 0; s_en[n] = 1; s_wc[n] = 0; s_dd[n] = 16'd0; s_rdy[n] = 1;
      mvalid = act && offer_from >= 0 && n >= offer_from;

      if (n < 5) s_rst[n] = 1;
      else case (ph)
        0: if (n == 6) begin s_wc[n] = 1; s_dd[n] = 16'd3; end
        1: if (mvalid && pix == 1 && stall_left > 0) begin s_rdy[n] = 0; stall_left--; end
        2: if (!c_written && act && pix == 1 && fdepth == 3) begin
             s_wc[n] = 1; s_dd[n] = 16'd5; c_written = 1;
           end
        3: begin
          s_en[n]  = ($urandom_range(0, 15) != 0);
          s_rdy[n] = ($urandom_range(0, 3) != 0);
          if ($urandom_range(0, 39) == 0) begin
            s_wc[n] = 1;
            case ($urandom_range(0, 7))
              0:       s_dd[n] = 16'd0;
              1:       s_dd[n] = 16'd40;
              default: s_dd[n] = 16'($urandom_range(1, 12));
            endcase
          end
        end
        4: begin
          if (e_state == 0) begin
            s_wc[n] = 1; s_dd[n] = 16'd4; e_state = 1;
          end else if (e_state == 1) begin
            if (mvalid && fdepth == 4) begin
              if (e_wait < 3) begin s_rdy[n] = 0; e_wait++; end
              else begin s_rst[n] = 1; e_state = 2; e_done_mark = frames_done; end
            end
          end else if (!zero_written && act && fdepth == 1000 && pix == 500) begin
            s_wc[n] = 1; s_dd[n] = 16'd0; zero_written = 1;
          end
        end
        default: begin
          if (!big_written && last_done_depth == 0) begin
            s_wc[n] = 1; s_dd[n] = 16'd2000; big_written = 1;
          end
          if (end_at < 0 && last_done_depth == DEPTH_MAX) end_at = n + 20;
        end
      endcase

      if (s_rst[n]) begin
        act = 0; pend = 0; dcfg = 1000; t0 = n + 1;
        offer_from = -1; next_read = -1; done_at = -1;
        exp_busy[n] = 0; exp_valid[n] = 0; exp_data[n] = 24'd0;
      end else begin
        tick  = (n >= t0) && ((n - t0) % P == P - 1);
        start = !act && pend && s_en[n];
        exp_busy[n]  = act;
        exp_valid[n] = mvalid;
        exp_data[n]  = mvalid ? ram[pix] : 24'd0;
        if (act) begin
          if (n == next_read) q_rd.push_back('{n, pix});
          if (mvalid && s_rdy[n]) begin
            q_acc.push_back('{n, int'(ram[pix])});
            if (pix == fdepth - 1) begin
              done_at = n + L; offer_from = -1;
            end else begin
              pix++; next_read = n + 1; offer_from = n + 3;
            end
          end
          if (n == done_at) begin
            q_done.push_back('{n, fdepth});
            act = 0; frames_done++; last_done_depth = fdepth;
          end
        end
        if (tick && pend && !start) q_ovr.push_back('{n, 0});
        if (start) begin
          d = (dcfg > DEPTH_MAX) ? DEPTH_MAX : dcfg;
          fdepth = d; pix = 0; act = 1;
          if (d == 0) begin
            done_at = n + L; offer_from = -1; next_read = -1;
          end else begin
            done_at = -1; next_read = n + 1; offer_from = n + 3;
          end
          if (ph == 1) stall_left = 7;
        end
        pend = tick || (pend && !start);
        if (s_wc[n]) dcfg = int'(s_dd[n]);
      end
      n++;
    end
    nc = n;
  endtask

  // Monitor: one observation per cycle, at the falling edge.
  ev_t e;
  always @(negedge clk) begin
    mcyc++;
    if (mcyc < nc) begin
      check("busy", busy, exp_busy[mcyc]);
      check("tx_valid", tx_valid, exp_valid[mcyc]);
      if (exp_valid[mcyc]) check("tx_data_hold", tx_data, exp_data[mcyc]);
      if (s_rst[mcyc])
        check("reset_outputs", {mem_rd_en, mem_rd_addr, tx_valid, tx_data, busy, frame_done, frame_overrun}, 0);
      if (mem_rd_en) begin
        if (q_rd.size() == 0) check("rd_unexpected", mcyc, -1);
        else begin
          e = q_rd.pop_front();
          check("rd_cycle", mcyc, e.cyc);
          check("rd_addr", mem_rd_addr, e.val);
        end
      end
      if (tx_valid && tx_ready) begin
        if (q_acc.size() == 0) check("accept_unexpected", mcyc, -1);
        else begin
          e = q_acc.pop_front();
          check("accept_cycle", mcyc, e.cyc);
          check("accept_data", tx_data, e.val);
        end
      end
      if (frame_done) begin
        if (q_done.size() == 0) check("done_unexpected", mcyc, -1);
        else begin
          e = q_done.pop_front();
          check("done_cycle", mcyc, e.cyc);
          $display("frame_done cycle %0d depth %0d", mcyc, e.val);
        end
      end
      if (frame_overrun) begin
        if (q_ovr.size() == 0) check("overrun_unexpected", mcyc, -1);
        else begin
          e = q_ovr.pop_front();
          check("overrun_cycle", mcyc, e.cyc);
        end
      end
    end
  end

  ev_t lf;
  initial begin
    rst = 1'b1; enable = 1'b0; write_config = 1'b0; data_depth = 16'd0; tx_ready = 1'b0;
    build();
    for (int n = 0; n < nc; n++) begin
      rst          = s_rst[n];
      enable       = s_en[n];
      write_config = s_wc[n];
      data_depth   = s_dd[n];
      tx_ready     = s_rdy[n];
      @(posedge clk);
      #1;
    end
    while (q_rd.size() > 0)   begin lf = q_rd.pop_front();   check("rd_missing", -1, lf.cyc);      end
    while (q_acc.size() > 0)  begin lf = q_acc.pop_front();  check("accept_missing", -1, lf.cyc);  end
    while (q_done.size() > 0) begin lf = q_done.pop_front(); check("done_missing", -1, lf.cyc);    end
    while (q_ovr.size() > 0)  begin lf = q_ovr.pop_front();  check("overrun_missing", -1, lf.cyc); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/ws2812_frame_scheduler.md
Name: ws2812_frame_scheduler

Overview:
Sequences periodic refresh of a WS2812 strip from the pixel RAM that the FIFO-side data controller fills (24-bit GRB words, one per address).
A frame-rate timer triggers each frame; the block reads pixels 0..depth-1 in order and hands each to the bit serializer over a valid/ready handshake.
After the last pixel it enforces the WS2812 latch (low) gap.
It sits between the pixel RAM read port and the serializer, and owns frame timing.

Parameters:
ADDR_WIDTH, 10, pixel RAM address width; maximum depth is 2^ADDR_WIDTH.
LATCH_CYCLES, 5000, length of the post-frame latch gap in clk cycles (≥50 µs at 100 MHz); must be ≥1.
FRAME_PERIOD, 1666667, frame timer period in clk cycles (60 Hz at 100 MHz); must be ≥2.
CNT_WIDTH, 24, width of the frame and latch counters; must hold FRAME_PERIOD-1 and LATCH_CYCLES.

Ports:
clk  in  1  system clock; all logic on rising edge.
rst  in  1  asynchronous, active-high reset.
enable  in  1  allows new frames to start; sampled only in WAIT_TICK.
data_depth  in  16  pixel count, captured when write_config=1.
write_config  in  1  single-cycle strobe that loads data_depth into the depth register.
mem_rd_en  out  1  pixel RAM read strobe.
mem_rd_addr  out  ADDR_WIDTH  pixel RAM read address.
mem_rd_data  in  24  RAM read data; valid exactly one cycle after mem_rd_en.
tx_valid  out  1  pixel offered to serializer.
tx_data  out  24  pixel word, GRB, bits [23:16]=G.
tx_ready  in  1  serializer accepts when tx_valid & tx_ready.
busy  out  1  high in every state except WAIT_TICK.
frame_done  out  1  one-cycle pulse on leaving LATCH.
frame_overrun  out  1  one-cycle pulse when a tick arrives while a tick is already pending.

Behaviour:
- Reset (async, immediate): state=WAIT_TICK; all outputs 0; depth_reg=1000; pixel index=0; frame counter=0; pending=0.
- Reset mid-frame aborts the frame immediately: tx_valid drops with no handshake, and no frame_done is produced.
- depth_reg loads on write_config. At frame start, depth_reg is copied to a shadow register, so a write_config mid-frame takes effect on the next frame.
- Shadow clamp: shadow = min(depth_reg, 2^ADDR_WIDTH).
- Frame timer: free-running 0..FRAME_PERIOD-1, always counting. tick=1 in the cycle the counter equals FRAME_PERIOD-1.
- pending flag: set on tick, cleared when a frame starts.
  - Tick while pending=1 → frame_overrun pulses the same cycle; ticks coalesce, so at most one pending frame.
- FSM:
  - WAIT_TICK: if pending & enable → load shadow, index=0, clear pending.
    - shadow=0 → go to LATCH (empty frame, no reads).
    - Otherwise → go to RD_ISSUE.
    - If enable=0, pending is kept.
  - RD_ISSUE: mem_rd_en=1, mem_rd_addr=index for exactly one cycle → RD_WAIT.
  - RD_WAIT: next edge captures mem_rd_data into tx_data and sets tx_valid=1 → SEND.
  - SEND: tx_valid and tx_data stay stable until tx_ready=1. On accept, tx_valid=0 next cycle.
    - If index == shadow-1 → go to LATCH with the latch counter cleared.
    - Otherwise index+1 → RD_ISSUE.
  - LATCH: count LATCH_CYCLES cycles (outputs idle). On the final cycle frame_done=1 → WAIT_TICK.
- Timing:
  - Minimum per-pixel cost is 3 cycles (tx_ready held high).
  - Frame latency from tick to first tx_valid is 3 cycles: WAIT_TICK sees pending one cycle after tick, then RD_ISSUE, then RD_WAIT.
- A tick during a frame sets pending; the next frame starts in the cycle after LATCH exits (one WAIT_TICK cycle).
- A tick and a frame start in the same cycle: the frame consumes the old pending, and the new tick sets pending (no overrun).
- Index arithmetic is ADDR_WIDTH+1 bits wide, so no wrap when depth = 2^ADDR_WIDTH.

Test Plan:
1. FRAME_PERIOD=100, LATCH_CYCLES=10, write_config depth=3, RAM[0..2]=0x112233/0x445566/0x778899, tx_ready=1, enable=1 → tx accepts exactly those 3 words in order; mem_rd_addr 0,1,2; frame_done 10 cycles after the 3rd accept; repeats every 100 cycles.
2. Same setup, tx_ready held 0 for 7 cycles on pixel 1 → tx_data stays 0x445566 and tx_valid stays 1 throughout; no extra RAM read.
3. write_config depth=5 during pixel 1 of a depth-3 frame → current frame sends 3 pixels; next frame sends 5.
4. FRAME_PERIOD=20 with depth=10 (frame > 20 cycles) → frame_overrun pulses for every second tick after the first pending tick; frames run back-to-back with a 1-cycle WAIT_TICK gap.
5. Assert rst for 1 cycle while in SEND → tx_valid, mem_rd_en, and busy go 0 immediately; no frame_done; after release, first frame begins 3 cycles after the next tick from pixel 0.
6. Depth=0 → no mem_rd_en and no tx_valid; frame_done pulses LATCH_CYCLES cycles after frame start. Depth=2000 with ADDR_WIDTH=10 → exactly 1024 pixels, addresses 0..1023.
